// File: rtl/lsu_ctrl.sv
// Load/store unit: takes one EXU request, waits LATENCY cycles, issues a single
// memory strobe, then returns extended load data (or an error) to WBU.
module lsu_ctrl #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        illegal;
    logic        misaligned;
    logic        access;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_mask;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign access     = (state == ACCESS);

    // Request legality is judged on the live request so the error path can skip WAIT.
    always_comb begin
        illegal = 1'b0;
        if (req_wen) begin
            illegal = (req_funct3 > 3'd2);
        end else begin
            case (req_funct3)
                3'b011, 3'b110, 3'b111: illegal = 1'b1;
                default:                illegal = 1'b0;
            endcase
        end
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        shifted = mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Replicating the store data puts it on every lane; the mask picks the live one.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                lane_mask  = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_mask  = 4'b0011 << addr_q[1:0];
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    assign mem_ren   = access & ~wen_q;
    assign mem_wen   = access & wen_q;
    assign mem_raddr = mem_ren ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_waddr = mem_wen ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata = mem_wen ? lane_wdata : 32'd0;
    assign mem_wmask = mem_wen ? {4'd0, lane_mask} : 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wen_q      <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wen_q    <= req_wen;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        if (illegal || misaligned) begin
                            state      <= RESP;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (LATENCY == 0) begin
                            state <= ACCESS;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= ACCESS;
                    else             cnt   <= cnt - 4'd1;
                end
                ACCESS: begin
                    resp_rdata <= wen_q ? 32'd0 : load_val;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: transaction-level reference model checked every cycle,
// directed cases pinned to literal values, then randomized traffic.
module tb_lsu_ctrl;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;

    lsu_ctrl #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // What one request must produce, from the ISA rules alone.
    typedef struct {
        logic        err;
        logic        wen;
        logic [31:0] rdata;
        logic [3:0]  mask;
        logic [31:0] wd;
        logic [31:0] addr;
        int          off;
    } exp_t;

    function automatic exp_t model(input logic w, input logic [2:0] f,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd);
        exp_t e;
        int size;
        logic [31:0] v;
        e.off   = int'(a[1:0]);
        e.wen   = w;
        e.wd    = wd;
        e.addr  = a & ~32'h3;
        e.mask  = 4'd0;
        e.rdata = 32'd0;
        size    = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        if (w) e.err = !(f inside {3'd0, 3'd1, 3'd2});
        else   e.err = !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if ((a % size) != 0) e.err = 1'b1;
        if (!e.err) begin
            if (w) begin
                e.mask = 4'(((1 << size) - 1) << e.off);
            end else begin
                v = rd >> (8 * e.off);
                if (size == 1) v = v % 256;
                if (size == 2) v = v % 65536;
                if (!f[2] && size == 1 && v >= 128)   v = v - 256;
                if (!f[2] && size == 2 && v >= 32768) v = v - 65536;
                e.rdata = v;
            end
        end
        return e;
    endfunction

    logic busy = 1'b0;
    int   k = 0;
    exp_t e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            k    <= 0;
        end else if (!busy) begin
            if (req_valid) begin
                busy <= 1'b1;
                k    <= 1;
                e    <= model(req_wen, req_funct3, req_addr, req_wdata, mem_rdata);
            end
        end else if (resp_ready && (e.err ? (k >= 1) : (k >= LAT + 2))) begin
            busy <= 1'b0;
        end else begin
            k <= k + 1;
        end
    end

    int          n_strobe = 0;
    int          s_k = 0;
    logic [31:0] s_addr = 32'd0;
    logic [31:0] s_wdata = 32'd0;
    logic [7:0]  s_mask = 8'd0;

    always @(negedge clk) begin
        logic exp_strobe;
        logic exp_rv;
        exp_strobe = busy && !e.err && (k == LAT + 1);
        exp_rv     = busy && (e.err ? (k >= 1) : (k >= LAT + 2));
        chk1("req_ready", req_ready, !busy);
        chk1("resp_valid", resp_valid, exp_rv);
        chk1("mem_ren", mem_ren, exp_strobe && !e.wen);
        chk1("mem_wen", mem_wen, exp_strobe && e.wen);
        if (rst) begin
            chk32("rst_rdata", resp_rdata, 32'd0);
            chk1("rst_err", resp_err, 1'b0);
            chk32("rst_wmask", {24'd0, mem_wmask}, 32'd0);
        end
        if (exp_rv) begin
            chk32("resp_rdata", resp_rdata, e.rdata);
            chk1("resp_err", resp_err, e.err);
        end
        if (exp_strobe) begin
            if (e.wen) begin
                chk32("mem_waddr", mem_waddr, e.addr);
                chk32("mem_wmask", {24'd0, mem_wmask}, {28'd0, e.mask});
                for (int i = 0; i < 4; i++)
                    if (e.mask[i])
                        chk32("mem_wdata_lane", {24'd0, mem_wdata[8*i +: 8]},
                              (e.wd >> (8 * (i - e.off))) & 32'hFF);
            end else begin
                chk32("mem_raddr", mem_raddr, e.addr);
            end
        end
        if (mem_ren || mem_wen) begin
            n_strobe++;
            s_k     = k;
            s_addr  = mem_ren ? mem_raddr : mem_waddr;
            s_wdata = mem_wdata;
            s_mask  = mem_wmask;
        end
    end

    logic [31:0] t_rdata;
    logic        t_err;
    int          t_wait;

    task automatic junk();
        req_valid  = 1'($urandom);
        req_wen    = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic txn(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int hold);
        @(negedge clk); #1;
        mem_rdata  = rd;
        req_valid  = 1'b1;
        req_wen    = w;
        req_funct3 = f;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = 1'b0;
        @(negedge clk); #1;
        junk();
        t_wait = 0;
        while (!resp_valid && t_wait < 40) begin
            @(negedge clk); #1;
            junk();
            t_wait++;
        end
        if (t_wait >= 40) chk1("resp_timeout", resp_valid, 1'b1);
        t_rdata = resp_rdata;
        t_err   = resp_err;
        repeat (hold) begin
            @(negedge clk); #1;
            junk();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        int n0;
        logic        w;
        logic [2:0]  f;
        logic [31:0] a;
        logic [2:0]  ld_f [5];
        ld_f = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Mid-run reset pulse while idle.
        #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;

        txn(1'b0, 3'b010, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 0);
        chk32("lw_rdata", t_rdata, 32'hDEAD_BEEF);
        chk1("lw_err", t_err, 1'b0);
        chk32("lw_resp_latency", t_wait, LAT + 1);
        chk32("lw_strobe_cycle", s_k, 3);
        chk32("lw_raddr", s_addr, 32'h8000_0004);

        txn(1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h80FF_0011, 1);
        chk32("lb_rdata", t_rdata, 32'hFFFF_FF80);
        txn(1'b0, 3'b100, 32'h8000_0003, 32'd0, 32'h80FF_0011, 0);
        chk32("lbu_rdata", t_rdata, 32'h0000_0080);

        n0 = n_strobe;
        txn(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555, 0);
        chk32("sh_strobes", n_strobe, n0 + 1);
        chk32("sh_waddr", s_addr, 32'h8000_0000);
        chk32("sh_wmask", {24'd0, s_mask}, 32'h0000_000C);
        chk32("sh_wdata_hi", {16'd0, s_wdata[31:16]}, 32'h0000_ABCD);
        chk32("sh_rdata", t_rdata, 32'd0);

        n0 = n_strobe;
        txn(1'b0, 3'b010, 32'h8000_0002, 32'd0, 32'hFFFF_FFFF, 0);
        chk1("lw_mis_err", t_err, 1'b1);
        chk32("lw_mis_rdata", t_rdata, 32'd0);
        chk32("lw_mis_latency", t_wait, 0);
        txn(1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        chk1("st_f100_err", t_err, 1'b1);
        chk32("err_no_strobe", n_strobe, n0);

        // Backpressure: per-cycle model checks cover the hold window.
        txn(1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'hBEEF_1234, 5);
        chk32("lhu_rdata", t_rdata, 32'h0000_BEEF);

        // Reset during WAIT abandons the store.
        n0 = n_strobe;
        @(negedge clk); #1;
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h8000_0010; req_wdata = 32'hCAFE_F00D;
        @(negedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk1("rst_async_ready", req_ready, 1'b1);
        chk1("rst_async_wen", mem_wen, 1'b0);
        @(negedge clk); #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        chk32("rst_wait_no_strobe", n_strobe, n0);

        for (int t = 0; t < 150; t++) begin
            w = 1'($urandom);
            if ($urandom_range(0, 3) != 0) f = w ? 3'($urandom_range(0, 2)) : ld_f[$urandom_range(0, 4)];
            else                           f = 3'($urandom);
            a = 32'h8000_0000 | ($urandom & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
            txn(w, f, a, $urandom, $urandom, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting directly upstream of the DPI-backed memory access block.
- Accepts one load or store request from EXU over a valid/ready handshake and applies a configurable wait-state latency.
- Drives a single-cycle read or write strobe with a word-aligned address, byte mask and lane-shifted write data.
- Extracts and sign/zero-extends load data, then returns the result to WBU over a valid/ready handshake.

Parameters:
LATENCY, 2, wait cycles between request acceptance and the memory access cycle (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  EXU request valid
req_ready  output  1  LSU can accept request
req_wen  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response valid to WBU
resp_ready  input  1  WBU accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal access
mem_ren  output  1  read strobe to memory block
mem_raddr  output  32  word-aligned read address
mem_rdata  input  32  read data, valid in same cycle as mem_ren
mem_wen  output  1  write strobe to memory block
mem_waddr  output  32  word-aligned write address
mem_wdata  output  32  write data shifted to byte lane
mem_wmask  output  8  byte enable, bits [3:0] used, [7:4] = 0

Behaviour:
- FSM states: IDLE, WAIT, ACCESS, RESP. Reset (async) forces IDLE, counter = 0, captured registers = 0.
- Reset values: resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_ren = 0, mem_wen = 0, mem_wmask = 0, addresses and wdata = 0. req_ready = 1 (IDLE).
- req_ready = 1 only in IDLE. A request is accepted when req_valid & req_ready at a rising edge; req_wen, funct3, addr and wdata are captured in that edge.
- Error check at acceptance:
  - Load funct3 must be in {000, 001, 010, 100, 101}; store funct3 must be in {000, 001, 010}; anything else is illegal.
  - Halfword requires addr[0] = 0; word requires addr[1:0] = 0.
  - On error: go directly to RESP with resp_err = 1 and resp_rdata = 0. No memory strobe is ever issued.
- Legal request, LATENCY > 0: go to WAIT with counter = LATENCY-1. Each cycle the counter decrements; at 0, go to ACCESS.
- Legal request, LATENCY = 0: go directly to ACCESS.
- ACCESS lasts exactly one cycle:
  - Load: mem_ren = 1, mem_raddr = {addr[31:2], 2'b00}.
  - Store: mem_wen = 1, mem_waddr = {addr[31:2], 2'b00}.
    - SB: mem_wmask = 4'b0001 << addr[1:0], mem_wdata = wdata[7:0] replicated and shifted to lane.
    - SH: mem_wmask = 4'b0011 << addr[1:0], with matching shift.
    - SW: mem_wmask = 4'b1111, mem_wdata = wdata.
  - Strobes are derived combinationally from state == ACCESS and are 0 in all other states, so each request performs exactly one memory operation.
- Load extraction: mem_rdata is shifted right by 8*addr[1:0], then bytes/halfwords are sign-extended (LB/LH) or zero-extended (LBU/LHU). The result is registered into resp_rdata at the end of ACCESS. Stores set resp_rdata = 0.
- RESP: resp_valid = 1; resp_rdata and resp_err are held stable until resp_valid & resp_ready, then return to IDLE. A new request is accepted no earlier than the following cycle (no bypass).
- Legal-access timing: accepted at edge T, ACCESS in cycle T+1+LATENCY, resp_valid first high in cycle T+2+LATENCY.
- Inputs req_* are ignored outside IDLE. A resp_ready asserted outside RESP has no effect.
- Reset asserted in WAIT or ACCESS: strobes drop immediately (async), the operation is abandoned, and no partial response is produced.

Test Plan:
- Reset then idle: rst pulse mid-sim -> req_ready = 1, resp_valid = 0, mem_ren = mem_wen = 0 throughout.
- LW, LATENCY = 2, addr = 0x80000004, mem_rdata = 0xDEADBEEF: accept at cycle 0 -> mem_ren only in cycle 3 with raddr 0x80000004; resp_valid in cycle 4 with rdata 0xDEADBEEF, err = 0.
- LB/LBU at addr 0x80000003 with mem_rdata 0x80FF0011 -> LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH at addr 0x80000002, wdata 0x1234ABCD -> single-cycle mem_wen, waddr 0x80000000, wmask 0x0C, wdata[31:16] = 0xABCD; resp_rdata = 0.
- LW at addr 0x80000002 -> no strobe; resp_valid one cycle after accept with err = 1, rdata = 0. Store with funct3 = 100 -> same error response.
- Backpressure and reset: resp_ready held 0 for 5 cycles -> resp_valid and data stable, req_ready = 0. Separately, rst asserted during WAIT -> no mem_wen ever, FSM back in IDLE.
